// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Data-memory access stage of the multi-cycle MIPS datapath. It takes one
// load/store request per start strobe, checks it for legality, runs a single
// req/ack bus transaction and reports completion with a one-cycle done pulse.
// Stores replicate the right-aligned store data onto the active byte lanes.
// Loads extract the addressed byte/halfword and sign- or zero-extend it.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   start      request strobe, sampled only while idle
//   we         1 = store, 0 = load
//   load_type  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU (loads only)
//   addr       byte address
//   wdata      right-aligned store data
//   be         byte enables from the byte-enable stage (stores only)
//   busy       high whenever the FSM is not idle
//   done       one-cycle completion pulse
//   rdata      extended load result, held until the next done
//   err        valid with done: illegal request or bus timeout
//   bus_req    bus request, held until ack or timeout
//   bus_we     bus write qualifier
//   bus_addr   word-aligned bus address
//   bus_be     bus lane enables
//   bus_wdata  lane-replicated store data
//   bus_ack    single-cycle memory acknowledge
//   bus_rdata  read data, valid with bus_ack
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16  // ISSUE cycles before abort, 2..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        we,
    input  logic [2:0]  load_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LH  = 3'b001,
        LT_LHU = 3'b010,
        LT_LB  = 3'b011,
        LT_LBU = 3'b100
    } load_t;

    // Counter value on the last ISSUE cycle before the transaction aborts.
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  count;
    logic [2:0]  ld_type_q;   // load type captured at the accepting edge
    logic [1:0]  ofs_q;       // byte offset captured at the accepting edge
    logic        is_store_q;

    // Request decode, evaluated against the live inputs in IDLE.
    logic        req_legal;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    // Load lane extraction from the bus read data.
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_result;

    // -------------------------------------------------------------------------
    // Request legality, lane enables and store-data replication
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        req_legal = 1'b0;
        req_be    = 4'b0000;
        req_wdata = 32'h0000_0000;

        if (we) begin
            // Store: the lane pattern alone decides the access width.
            case (be)
                4'b1111: begin
                    req_legal = 1'b1;
                    req_be    = be;
                    req_wdata = wdata;
                end
                4'b0011, 4'b1100: begin
                    req_legal = 1'b1;
                    req_be    = be;
                    req_wdata = {2{wdata[15:0]}};
                end
                4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                    req_legal = 1'b1;
                    req_be    = be;
                    req_wdata = {4{wdata[7:0]}};
                end
                default: begin
                    req_legal = 1'b0;
                end
            endcase
        end else begin
            case (load_type)
                LT_LW: begin
                    req_legal = (addr[1:0] == 2'b00);
                    req_be    = 4'b1111;
                end
                LT_LH, LT_LHU: begin
                    req_legal = ~addr[0];
                    req_be    = addr[1] ? 4'b1100 : 4'b0011;
                end
                LT_LB, LT_LBU: begin
                    req_legal = 1'b1;
                    req_be    = 4'b0001 << addr[1:0];
                end
                default: begin
                    req_legal = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Load result: select the addressed lane, then extend
    // -------------------------------------------------------------------------
    always_comb begin
        lane_byte   = 8'h00;
        lane_half   = 16'h0000;
        load_result = 32'h0000_0000;

        case (ofs_q)
            2'd0:    lane_byte = bus_rdata[7:0];
            2'd1:    lane_byte = bus_rdata[15:8];
            2'd2:    lane_byte = bus_rdata[23:16];
            default: lane_byte = bus_rdata[31:24];
        endcase

        lane_half = ofs_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

        case (ld_type_q)
            LT_LW:   load_result = bus_rdata;
            LT_LH:   load_result = {{16{lane_half[15]}}, lane_half};
            LT_LHU:  load_result = {16'h0000, lane_half};
            LT_LB:   load_result = {{24{lane_byte[7]}}, lane_byte};
            LT_LBU:  load_result = {24'h000000, lane_byte};
            default: load_result = 32'h0000_0000;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            state      <= IDLE;
            count      <= 8'd0;
            ld_type_q  <= 3'b000;
            ofs_q      <= 2'b00;
            is_store_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= 32'h0000_0000;
            err        <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0000_0000;
            bus_be     <= 4'b0000;
            bus_wdata  <= 32'h0000_0000;
        end else begin
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        // Everything the transaction needs later is captured
                        // here, so input changes after this edge are harmless.
                        ld_type_q  <= load_type;
                        ofs_q      <= addr[1:0];
                        is_store_q <= we;
                        busy       <= 1'b1;
                        if (req_legal) begin
                            state     <= ISSUE;
                            count     <= 8'd0;
                            bus_req   <= 1'b1;
                            bus_we    <= we;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= req_be;
                            bus_wdata <= req_wdata;
                        end else begin
                            // Rejected without touching the bus.
                            state <= DONE;
                            err   <= 1'b1;
                            rdata <= 32'h0000_0000;
                        end
                    end
                end

                ISSUE: begin
                    count <= count + 8'd1;
                    // Ack is tested first so it wins over a same-cycle timeout.
                    if (bus_ack) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        err     <= 1'b0;
                        if (!is_store_q) begin
                            rdata <= load_result;
                        end
                    end else if (count == LAST_COUNT) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        err     <= 1'b1;
                        rdata   <= 32'h0000_0000;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    bus_req <= 1'b0;
                    bus_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        we;
    logic [2:0]  load_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .we        (we),
        .load_type (load_type),
        .addr      (addr),
        .wdata     (wdata),
        .be        (be),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    // One directed transaction with its hand-computed expectations.
    // ack_dly: ISSUE cycle (1-based) in which bus_ack is driven; 0 = never.
    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  load_type;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] bus_rdata;
        int          ack_dly;
        logic        legal;
        logic [31:0] exp_bus_addr;
        logic [3:0]  exp_bus_be;
        logic [31:0] exp_bus_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic w, input logic [2:0] lt,
                                input logic [31:0] a, input logic [31:0] wd, input logic [3:0] b,
                                input logic [31:0] rd, input int ack, input logic legal,
                                input logic [31:0] e_addr, input logic [3:0] e_be,
                                input logic [31:0] e_wd, input logic [31:0] e_rd, input logic e_err);
        vec_t v;
        v.name = name; v.we = w; v.load_type = lt; v.addr = a; v.wdata = wd; v.be = b;
        v.bus_rdata = rd; v.ack_dly = ack; v.legal = legal;
        v.exp_bus_addr = e_addr; v.exp_bus_be = e_be; v.exp_bus_wdata = e_wd;
        v.exp_rdata = e_rd; v.exp_err = e_err;
        return v;
    endfunction

    // Drives one request, plays the memory side and checks the outcome.
    task automatic run_vec(input vec_t v);
        int          done_t;
        int          req_cycles;
        int          exp_done_t;
        int          exp_req;
        logic        seen_req;
        logic        cap_we;
        logic [31:0] cap_addr;
        logic [3:0]  cap_be;
        logic [31:0] cap_wdata;
        logic        cap_err;
        logic [31:0] cap_rdata;

        done_t = 0; req_cycles = 0; seen_req = 1'b0;
        cap_we = 1'b0; cap_addr = '0; cap_be = '0; cap_wdata = '0;
        cap_err = 1'b0; cap_rdata = '0;

        if (!v.legal) begin
            exp_done_t = 2; exp_req = 0;
        end else if (v.ack_dly == 0 || v.ack_dly > 16) begin
            exp_done_t = 18; exp_req = 16;
        end else begin
            exp_done_t = v.ack_dly + 2; exp_req = v.ack_dly;
        end

        @(negedge clk);
        we = v.we; load_type = v.load_type; addr = v.addr; wdata = v.wdata; be = v.be;
        bus_rdata = v.bus_rdata; start = 1'b1;
        @(negedge clk);
        // Scramble the request inputs: the DUT must have captured them already.
        start = 1'b0; we = ~v.we; load_type = 3'b111; addr = 32'hFFFF_FFFF;
        wdata = 32'h0; be = 4'b0110;
        for (int t = 1; t <= 40; t++) begin
            if (t > 1) @(negedge clk);
            if (done) begin
                done_t = t; cap_err = err; cap_rdata = rdata;
                break;
            end
            if (bus_req) begin
                req_cycles++;
                if (!seen_req) begin
                    seen_req = 1'b1;
                    cap_we = bus_we; cap_addr = bus_addr; cap_be = bus_be; cap_wdata = bus_wdata;
                end
            end
            bus_ack = (v.ack_dly != 0 && t == v.ack_dly);
        end
        bus_ack = 1'b0;

        check({v.name, "_done_latency"}, done_t, exp_done_t);
        check({v.name, "_req_cycles"}, req_cycles, exp_req);
        check({v.name, "_err"}, {31'b0, cap_err}, {31'b0, v.exp_err});
        if (!v.we || !v.legal || v.exp_err)
            check({v.name, "_rdata"}, cap_rdata, v.exp_rdata);
        if (v.legal) begin
            check({v.name, "_bus_we"}, {31'b0, cap_we}, {31'b0, v.we});
            check({v.name, "_bus_addr"}, cap_addr, v.exp_bus_addr);
            check({v.name, "_bus_be"}, {28'b0, cap_be}, {28'b0, v.exp_bus_be});
            if (v.we) check({v.name, "_bus_wdata"}, cap_wdata, v.exp_bus_wdata);
        end
        @(negedge clk);
        check({v.name, "_done_one_cycle"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int n_done;

        rst = 1'b1; start = 1'b0; we = 1'b0; load_type = 3'b000; addr = '0;
        wdata = '0; be = '0; bus_ack = 1'b0; bus_rdata = '0;

        // Stores (exp_rdata unused), loads, illegal requests, timeouts.
        vecs.push_back(mk("sw",        1, 3'b000, 32'h100, 32'hDEADBEEF, 4'b1111, 32'h0,         2,  1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0,         0));
        vecs.push_back(mk("sb",        1, 3'b000, 32'h106, 32'h000000A5, 4'b0100, 32'h0,         1,  1, 32'h104, 4'b0100, 32'hA5A5A5A5, 32'h0,         0));
        vecs.push_back(mk("sh",        1, 3'b000, 32'h102, 32'h00001234, 4'b1100, 32'h0,         3,  1, 32'h100, 4'b1100, 32'h12341234, 32'h0,         0));
        vecs.push_back(mk("lb_203",    0, 3'b011, 32'h203, 32'h0,        4'b0000, 32'h80FF7F01, 1,  1, 32'h200, 4'b1000, 32'h0,         32'hFFFFFF80, 0));
        vecs.push_back(mk("lbu_203",   0, 3'b100, 32'h203, 32'h0,        4'b0000, 32'h80FF7F01, 1,  1, 32'h200, 4'b1000, 32'h0,         32'h00000080, 0));
        vecs.push_back(mk("lh_202",    0, 3'b001, 32'h202, 32'h0,        4'b0000, 32'h80FF7F01, 2,  1, 32'h200, 4'b1100, 32'h0,         32'hFFFF80FF, 0));
        vecs.push_back(mk("lhu_202",   0, 3'b010, 32'h202, 32'h0,        4'b0000, 32'h80FF7F01, 1,  1, 32'h200, 4'b1100, 32'h0,         32'h000080FF, 0));
        vecs.push_back(mk("lw_204",    0, 3'b000, 32'h204, 32'h0,        4'b0000, 32'h80FF7F01, 1,  1, 32'h204, 4'b1111, 32'h0,         32'h80FF7F01, 0));
        vecs.push_back(mk("lb_201",    0, 3'b011, 32'h201, 32'h0,        4'b0000, 32'h80FF7F01, 1,  1, 32'h200, 4'b0010, 32'h0,         32'h0000007F, 0));
        vecs.push_back(mk("lh_200",    0, 3'b001, 32'h200, 32'h0,        4'b0000, 32'h80FF7F01, 1,  1, 32'h200, 4'b0011, 32'h0,         32'h00007F01, 0));
        vecs.push_back(mk("ill_lw302", 0, 3'b000, 32'h302, 32'h0,        4'b0000, 32'h12345678, 1,  0, 32'h0,   4'b0000, 32'h0,         32'h0,         1));
        vecs.push_back(mk("ill_be0110",1, 3'b000, 32'h300, 32'h11223344, 4'b0110, 32'h0,         1,  0, 32'h0,   4'b0000, 32'h0,         32'h0,         1));
        vecs.push_back(mk("lbu_200",   0, 3'b100, 32'h200, 32'h0,        4'b0000, 32'h80FF7F01, 1,  1, 32'h200, 4'b0001, 32'h0,         32'h00000001, 0));
        vecs.push_back(mk("ill_lt111", 0, 3'b111, 32'h300, 32'h0,        4'b0000, 32'h12345678, 1,  0, 32'h0,   4'b0000, 32'h0,         32'h0,         1));
        vecs.push_back(mk("ill_be0000",1, 3'b000, 32'h300, 32'h0,        4'b0000, 32'h0,         1,  0, 32'h0,   4'b0000, 32'h0,         32'h0,         1));
        vecs.push_back(mk("ill_lh201", 0, 3'b001, 32'h201, 32'h0,        4'b0000, 32'h12345678, 1,  0, 32'h0,   4'b0000, 32'h0,         32'h0,         1));
        vecs.push_back(mk("lhu_to",    0, 3'b010, 32'h202, 32'h0,        4'b0000, 32'h80FF7F01, 1,  1, 32'h200, 4'b1100, 32'h0,         32'h000080FF, 0));
        vecs.push_back(mk("lw_timeout",0, 3'b000, 32'h400, 32'h0,        4'b0000, 32'hCAFEF00D, 0,  1, 32'h400, 4'b1111, 32'h0,         32'h0,         1));
        vecs.push_back(mk("sw_timeout",1, 3'b000, 32'h408, 32'h55AA55AA, 4'b1111, 32'h0,         0,  1, 32'h408, 4'b1111, 32'h55AA55AA, 32'h0,         1));
        vecs.push_back(mk("lbu_ack16", 0, 3'b100, 32'h203, 32'h0,        4'b0000, 32'h80FF7F01, 16, 1, 32'h200, 4'b1000, 32'h0,         32'h00000080, 0));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy",      {31'b0, busy},    32'd0);
        check("rst_done",      {31'b0, done},    32'd0);
        check("rst_err",       {31'b0, err},     32'd0);
        check("rst_rdata",     rdata,            32'd0);
        check("rst_bus_req",   {31'b0, bus_req}, 32'd0);
        check("rst_bus_we",    {31'b0, bus_we},  32'd0);
        check("rst_bus_addr",  bus_addr,         32'd0);
        check("rst_bus_be",    {28'b0, bus_be},  32'd0);
        check("rst_bus_wdata", bus_wdata,        32'd0);

        // bus_ack while idle is ignored
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_busy", {31'b0, busy}, 32'd0);
        check("idle_ack_done", {31'b0, done}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // start held high through ISSUE and DONE: exactly one completion
        @(negedge clk);
        we = 1'b0; load_type = 3'b000; addr = 32'h500; bus_rdata = 32'h0BADF00D; start = 1'b1;
        n_done = 0;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (t == 1) addr = 32'h504;          // must not affect the running access
            if (t >= 5) start = 1'b0;            // drop before the FSM is idle again
            bus_ack = (t == 3);
            if (done) begin
                n_done++;
                check("busy_start_rdata", rdata, 32'h0BADF00D);
                check("busy_start_latency", t, 5);
            end
        end
        bus_ack = 1'b0;
        check("busy_start_done_count", n_done, 1);
        check("busy_start_idle", {31'b0, busy}, 32'd0);

        // Reset in the middle of ISSUE
        @(negedge clk);
        we = 1'b1; be = 4'b1111; addr = 32'h600; wdata = 32'h13572468; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_rst_req_before", {31'b0, bus_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_bus_req",   {31'b0, bus_req}, 32'd0);
        check("mid_rst_busy",      {31'b0, busy},    32'd0);
        check("mid_rst_bus_addr",  bus_addr,         32'd0);
        check("mid_rst_bus_wdata", bus_wdata,        32'd0);
        n_done = 0;
        for (int t = 0; t < 25; t++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("mid_rst_no_done", n_done, 0);
        check("mid_rst_still_idle", {31'b0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the byte-enable generator in the multi-cycle MIPS datapath.
- Consumes the generated 4-bit byte-enable together with the ALU address and the store data, and runs one data-memory bus transaction per request using a req/ack handshake.
- Stores: replicates the write data onto the active byte lanes.
- Loads: extracts the addressed byte or halfword and sign- or zero-extends it.
- The main controller waits on done in its MEM state.

Parameters:
TIMEOUT, 16, number of ISSUE cycles without bus_ack before the transaction aborts with err (legal range 2..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request strobe, sampled only in IDLE
we  input  1  1 = store, 0 = load
load_type  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; ignored when we=1
addr  input  32  byte address (ALUOut)
wdata  input  32  store data, right-aligned (rt)
be  input  4  byte enables from the byte-enable stage; used only when we=1
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
rdata  output  32  extended load result, held until the next done
err  output  1  valid with done: misalignment, illegal be/load_type, or timeout
bus_req  output  1  bus request, held until ack or timeout
bus_we  output  1  bus write strobe qualifier
bus_addr  output  32  word address {addr[31:2],2'b00}
bus_be  output  4  lane enables on the bus
bus_wdata  output  32  lane-replicated store data
bus_ack  input  1  memory acknowledge, single-cycle
bus_rdata  input  32  read data, valid when bus_ack=1

Behaviour:
- Reset values: every output is registered and resets to 0; the FSM resets to IDLE and the timeout counter to 0.
- FSM states: IDLE, ISSUE, DONE.
- IDLE with start=1, checking the request first:
  - Store legality: be must be 1111 (word), 0011 or 1100 (half), or one-hot (byte). Any other be value, including 0000, is illegal.
  - Load legality: load_type must be in 000..100. LW requires addr[1:0]=00. LH/LHU require addr[0]=0.
- IDLE with start=1, illegal request: go to DONE with err latched to 1, rdata=0 and no bus activity.
- IDLE with start=1, legal request: go to ISSUE. Register bus_req=1, bus_we=we, bus_addr and bus_be, and clear the counter.
  - Store bus_be = be.
  - Load bus_be: LW gives 1111; LH/LHU give 0011 if addr[1]=0, else 1100; LB/LBU give the one-hot lane at addr[1:0].
- Store lane replication into bus_wdata:
  - word: wdata as-is
  - half: {wdata[15:0], wdata[15:0]}
  - byte: {4{wdata[7:0]}}
- ISSUE: the counter increments each cycle.
  - bus_ack=1: drop bus_req. For a load, latch the extracted lane of bus_rdata, sign-extended for LH/LB and zero-extended for LHU/LBU (LW unchanged). Set err=0 and go to DONE.
  - Timeout: counter reaches TIMEOUT-1 with bus_ack=0. Drop bus_req, set err=1 and rdata=0, go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE: done=1 for exactly this cycle, then return to IDLE. err and rdata hold until the next DONE.
- Latency: a legal request with ack in the first ISSUE cycle gives done 3 cycles after the start sample edge. An illegal request gives done 2 cycles after.
- start while busy: ignored and not queued. Inputs are sampled only at the IDLE edge; later changes have no effect on the transaction.
- bus_ack outside ISSUE: ignored.
- Reset mid-transaction: all outputs go to 0 and the FSM to IDLE at the next edge. No done pulse is produced.

Test Plan:
- Store word: we=1, be=1111, addr=0x100, wdata=0xDEADBEEF, ack after 2 cycles -> bus_addr=0x100, bus_be=1111, bus_wdata=0xDEADBEEF, done pulse once, err=0.
- Store byte: be=0100, addr=0x106, wdata=0x000000A5 -> bus_addr=0x104, bus_be=0100, bus_wdata=0xA5A5A5A5; store half with be=1100, wdata=0x1234 -> bus_wdata=0x12341234.
- Loads from addr 0x203 with bus_rdata=0x80FF7F01: LB -> rdata=0xFFFFFF80, LBU -> 0x00000080. Loads from addr 0x202, same data: LH -> 0xFFFF80FF, LHU -> 0x000080FF.
- Illegal requests: LW at 0x302, store be=0110, load_type=111 -> bus_req never asserts, done 2 cycles after start, err=1, rdata=0.
- Timeout: TIMEOUT=16, bus_ack held 0 -> bus_req high for exactly 16 cycles, then done with err=1. Ack coinciding with the last cycle -> err=0.
- Control corners: start pulses during ISSUE and DONE are ignored (one done per accepted start). rst asserted in ISSUE -> bus_req=0 and busy=0 next cycle, no done.
